// File: rtl/ann_neuron_seq_if.sv
// Bus bundle for ann_neuron_seq: input pair handshake, result handshake,
// coefficient write port, status outputs and the FSM state for observation.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid must not depend on ready, and the producer holds its data
// stable while valid is high and ready is low.
`timescale 1ns/1ps
interface ann_neuron_seq_if #(
    parameter int CW   = 8,
    parameter int CNTW = 16
);
    logic            in_valid;
    logic            in_ready;
    logic            a;
    logic            b;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [CW-1:0]   cfg_data;
    logic            out_valid;
    logic            out_ready;
    logic            y;
    logic            busy;
    logic [CNTW-1:0] inf_count;
    logic [2:0]      dbg_state;

    // Producer / consumer / configuration side.
    modport master (
        output in_valid, a, b, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, out_valid, y, busy, inf_count, dbg_state
    );

    // Neuron controller side.
    modport slave (
        input  in_valid, a, b, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, out_valid, y, busy, inf_count, dbg_state
    );
endinterface

// File: rtl/ann_neuron_seq.sv
// Time-multiplexed 2-2-1 step-activation network. One shared neuron datapath
// is evaluated three times per inference (H1, H2, output). Nine programmable
// signed coefficients default to the NXOR network at x2 scale.
`timescale 1ns/1ps
module ann_neuron_seq #(
    parameter int CW   = 8,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    ann_neuron_seq_if.slave bus
);
    // Sum width with two guard bits: |wa|+|wb|+|bias| never exceeds 3*2^(CW-1).
    localparam int SW = CW + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EV_H1  = 3'd1,
        EV_H2  = 3'd2,
        EV_OUT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic signed [CW-1:0] coeff_q [0:8];
    logic                 a_q, b_q;
    logic                 h1_q, h2_q;
    logic                 y_q;
    logic                 out_valid_q;
    logic [CNTW-1:0]      cnt_q;

    logic                 accept;
    logic                 cfg_hit;
    logic                 out_fire;
    logic signed [CW-1:0] wa, wb, bias;
    logic                 x0, x1;
    logic signed [SW-1:0] pa, pb, pbias, sum;
    logic                 act;

    // Handshake qualifiers: a config write in IDLE blocks input acceptance.
    assign accept   = (state_q == IDLE) && bus.in_valid && !bus.cfg_we;
    assign cfg_hit  = (state_q == IDLE) && bus.cfg_we && (bus.cfg_addr < 4'd9);
    assign out_fire = (state_q == DONE) && out_valid_q && bus.out_ready;

    // Next-state logic for the evaluation sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)   state_d = EV_H1;
            EV_H1:                 state_d = EV_H2;
            EV_H2:                 state_d = EV_OUT;
            EV_OUT:                state_d = DONE;
            DONE:    if (out_fire) state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // Operand select for the shared neuron, driven by the current state.
    always_comb begin
        wa   = coeff_q[0];
        wb   = coeff_q[1];
        bias = coeff_q[2];
        x0   = a_q;
        x1   = b_q;
        case (state_q)
            EV_H2: begin
                wa   = coeff_q[3];
                wb   = coeff_q[4];
                bias = coeff_q[5];
            end
            EV_OUT: begin
                wa   = coeff_q[6];
                wb   = coeff_q[7];
                bias = coeff_q[8];
                x0   = h1_q;
                x1   = h2_q;
            end
            default: ;
        endcase
    end

    // Neuron: binary inputs gate the weights; step fires only on a strictly positive sum.
    always_comb begin
        pa    = '0;
        pb    = '0;
        pbias = SW'(bias);
        if (x0) pa = SW'(wa);
        if (x1) pb = SW'(wb);
        sum   = pa + pb + pbias;
        act   = !sum[SW-1] && (sum != '0);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Coefficient bank: writable only in IDLE, restored to the NXOR net on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_q[0] <= CW'(2);
            coeff_q[1] <= CW'(2);
            coeff_q[2] <= CW'(-1);
            coeff_q[3] <= CW'(2);
            coeff_q[4] <= CW'(2);
            coeff_q[5] <= CW'(-3);
            coeff_q[6] <= CW'(-2);
            coeff_q[7] <= CW'(4);
            coeff_q[8] <= CW'(1);
        end else if (cfg_hit) begin
            coeff_q[bus.cfg_addr] <= $signed(bus.cfg_data);
        end
    end

    // Datapath registers: latched inputs, hidden activations, result and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            h1_q        <= 1'b0;
            h2_q        <= 1'b0;
            y_q         <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (state_q == EV_H1) h1_q <= act;
            if (state_q == EV_H2) h2_q <= act;
            if (state_q == EV_OUT) begin
                y_q         <= act;
                out_valid_q <= 1'b1;
            end
            if (out_fire) begin
                out_valid_q <= 1'b0;
                cnt_q       <= cnt_q + CNTW'(1);
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !bus.cfg_we;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.inf_count = cnt_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_ann_neuron_seq.sv
// Directed bench for ann_neuron_seq: NXOR/XOR truth tables, latency,
// back-pressure, config guarding, coefficient extremes, reset mid-inference
// and counter wrap on a narrow-counter instance.
`timescale 1ns/1ps
module tb_ann_neuron_seq;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ann_neuron_seq_if #(.CW(8), .CNTW(16)) intf ();
    ann_neuron_seq_if #(.CW(8), .CNTW(2))  intf2 ();

    ann_neuron_seq #(.CW(8), .CNTW(16)) dut  (.clk(clk), .rst(rst), .bus(intf));
    ann_neuron_seq #(.CW(8), .CNTW(2))  dut2 (.clk(clk), .rst(rst), .bus(intf2));

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EV_H1 = 3'd1;
    localparam logic [2:0] S_EV_H2 = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd4;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_cnt     = '0;

    logic signed [7:0] defaults [9] = '{8'sd2, 8'sd2, -8'sd1, 8'sd2, 8'sd2, -8'sd3, -8'sd2, 8'sd4, 8'sd1};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = '0;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [7:0] data);
        intf.cfg_we   = 1'b1;
        intf.cfg_addr = addr;
        intf.cfg_data = data;
        tick();
        intf.cfg_we   = 1'b0;
    endtask

    // Present (a,b), wait for accept, then measure latency to out_valid and check y.
    task automatic send_and_wait(input logic av, input logic bv, input logic exp_y, input string name);
        int n;
        intf.a        = av;
        intf.b        = bv;
        intf.in_valid = 1'b1;
        #1;
        n = 0;
        while (!intf.in_ready && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (intf.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: in_ready=%b required 1", name, intf.in_ready);
            intf.in_valid = 1'b0;
            return;
        end
        tick();
        intf.in_valid = 1'b0;
        n = 0;
        while (!intf.out_valid && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 3) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles required 3", name, n);
        end
        vectors++;
        if (intf.y !== exp_y) begin
            miscompares++;
            $display("FAIL %s y: got %b required %b", name, intf.y, exp_y);
        end
    endtask

    task automatic handshake(input string name);
        intf.out_ready = 1'b1;
        #1;
        vectors++;
        if (intf.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s in_ready in handshake cycle: got %b required 0", name, intf.in_ready);
        end
        tick();
        intf.out_ready = 1'b0;
        exp_cnt++;
        vectors++;
        if (intf.out_valid !== 1'b0 || intf.inf_count !== exp_cnt || intf.dbg_state !== S_IDLE) begin
            miscompares++;
            $display("FAIL %s after handshake: out_valid=%b inf_count=%0d state=%0d required 0 %0d %0d",
                     name, intf.out_valid, intf.inf_count, intf.dbg_state, exp_cnt, S_IDLE);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (intf.in_ready !== 1'b1 || intf.out_valid !== 1'b0 || intf.y !== 1'b0 ||
            intf.busy !== 1'b0 || intf.inf_count !== 16'd0 || intf.dbg_state !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset outputs: in_ready=%b out_valid=%b y=%b busy=%b cnt=%0d state=%0d required 1 0 0 0 0 0",
                     intf.in_ready, intf.out_valid, intf.y, intf.busy, intf.inf_count, intf.dbg_state);
        end
        vectors++;
        if (dut.h1_q !== 1'b0 || dut.h2_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset hidden: h1=%b h2=%b required 0 0", dut.h1_q, dut.h2_q);
        end
    endtask

    task automatic test_nxor();
        logic exp_y [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send_and_wait(i[1], i[0], exp_y[i], "nxor");
            handshake("nxor");
        end
        vectors++;
        if (intf.inf_count !== 16'd4) begin
            miscompares++;
            $display("FAIL nxor inf_count: got %0d required 4", intf.inf_count);
        end
    endtask

    task automatic test_xor();
        logic exp_y [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        cfg_write(4'd6, 8'h02);
        cfg_write(4'd7, 8'hFC);
        cfg_write(4'd8, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            send_and_wait(i[1], i[0], exp_y[i], "xor");
            handshake("xor");
        end
    endtask

    task automatic test_back_pressure();
        send_and_wait(1'b0, 1'b1, 1'b1, "backpressure");
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (intf.out_valid !== 1'b1 || intf.y !== 1'b1 || intf.in_ready !== 1'b0 || intf.inf_count !== exp_cnt) begin
                miscompares++;
                $display("FAIL backpressure hold %0d: out_valid=%b y=%b in_ready=%b cnt=%0d required 1 1 0 %0d",
                         k, intf.out_valid, intf.y, intf.in_ready, intf.inf_count, exp_cnt);
            end
            tick();
        end
        handshake("backpressure");
    endtask

    task automatic test_cfg_guard();
        int n;
        logic bad;
        do_reset();
        intf.a        = 1'b1;
        intf.b        = 1'b1;
        intf.in_valid = 1'b1;
        tick();
        intf.in_valid = 1'b0;
        tick();
        vectors++;
        if (intf.dbg_state !== S_EV_H2) begin
            miscompares++;
            $display("FAIL cfg_guard state: got %0d required %0d", intf.dbg_state, S_EV_H2);
        end
        intf.cfg_we   = 1'b1;
        intf.cfg_addr = 4'd0;
        intf.cfg_data = 8'd99;
        tick();
        intf.cfg_we   = 1'b0;
        n = 0;
        while (!intf.out_valid && n < 10) begin
            tick();
            n++;
        end
        vectors++;
        if (intf.out_valid !== 1'b1 || intf.y !== 1'b1 || dut.coeff_q[0] !== 8'sd2) begin
            miscompares++;
            $display("FAIL cfg_guard busy write: out_valid=%b y=%b coeff0=%0d required 1 1 2",
                     intf.out_valid, intf.y, dut.coeff_q[0]);
        end
        handshake("cfg_guard");
        cfg_write(4'd12, 8'd99);
        bad = 1'b0;
        for (int i = 0; i < 9; i++) if (dut.coeff_q[i] !== defaults[i]) bad = 1'b1;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL cfg_guard addr12: coefficients differ from defaults, coeff4=%0d required 2", dut.coeff_q[4]);
        end
        intf.a        = 1'b0;
        intf.b        = 1'b0;
        intf.in_valid = 1'b1;
        intf.cfg_we   = 1'b1;
        intf.cfg_addr = 4'd2;
        intf.cfg_data = 8'hFF;
        #1;
        vectors++;
        if (intf.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_guard write-wins in_ready: got %b required 0", intf.in_ready);
        end
        tick();
        intf.cfg_we = 1'b0;
        vectors++;
        if (intf.dbg_state !== S_IDLE || intf.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_guard write-wins accept: state=%0d busy=%b required 0 0", intf.dbg_state, intf.busy);
        end
        send_and_wait(1'b0, 1'b0, 1'b1, "cfg_guard_defaults");
        handshake("cfg_guard_defaults");
    endtask

    task automatic test_extremes();
        do_reset();
        // Output neuron passes h1 straight through: y = step(2*h1 - 1).
        cfg_write(4'd6, 8'h02);
        cfg_write(4'd7, 8'h00);
        cfg_write(4'd8, 8'hFF);
        for (int i = 0; i < 3; i++) cfg_write(4'(i), 8'h7F);
        send_and_wait(1'b1, 1'b1, 1'b1, "ext_pos381");
        handshake("ext_pos381");
        for (int i = 0; i < 3; i++) cfg_write(4'(i), 8'h80);
        send_and_wait(1'b1, 1'b1, 1'b0, "ext_neg384");
        handshake("ext_neg384");
        cfg_write(4'd0, 8'h02);
        cfg_write(4'd1, 8'hFE);
        cfg_write(4'd2, 8'h00);
        send_and_wait(1'b1, 1'b1, 1'b0, "ext_sum0");
        handshake("ext_sum0");
        send_and_wait(1'b1, 1'b0, 1'b1, "ext_sum2");
        handshake("ext_sum2");
        send_and_wait(1'b0, 1'b0, 1'b0, "ext_bias0");
        handshake("ext_bias0");
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        cfg_write(4'd8, 8'hFF);
        send_and_wait(1'b0, 1'b0, 1'b0, "rst_pre");
        handshake("rst_pre");
        intf.a        = 1'b0;
        intf.b        = 1'b0;
        intf.in_valid = 1'b1;
        tick();
        intf.in_valid = 1'b0;
        vectors++;
        if (intf.dbg_state !== S_EV_H1) begin
            miscompares++;
            $display("FAIL rst_h1 state before: got %0d required %0d", intf.dbg_state, S_EV_H1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        vectors++;
        if (intf.dbg_state !== S_IDLE || intf.out_valid !== 1'b0 || intf.inf_count !== 16'd0 ||
            intf.busy !== 1'b0 || intf.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_h1 after: state=%0d out_valid=%b cnt=%0d busy=%b in_ready=%b required 0 0 0 0 1",
                     intf.dbg_state, intf.out_valid, intf.inf_count, intf.busy, intf.in_ready);
        end
        send_and_wait(1'b0, 1'b0, 1'b1, "rst_defaults");
        handshake("rst_defaults");
        send_and_wait(1'b1, 1'b1, 1'b1, "rst_done_pre");
        tick();
        vectors++;
        if (intf.dbg_state !== S_DONE) begin
            miscompares++;
            $display("FAIL rst_done state before: got %0d required %0d", intf.dbg_state, S_DONE);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        vectors++;
        if (intf.dbg_state !== S_IDLE || intf.out_valid !== 1'b0 || intf.inf_count !== 16'd0 || intf.y !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_done after: state=%0d out_valid=%b cnt=%0d y=%b required 0 0 0 0",
                     intf.dbg_state, intf.out_valid, intf.inf_count, intf.y);
        end
        n = 0;
        for (int i = 0; i < 9; i++) if (dut.coeff_q[i] !== defaults[i]) n++;
        vectors++;
        if (n != 0) begin
            miscompares++;
            $display("FAIL rst_done coefficients: %0d differ from defaults, required 0", n);
        end
    endtask

    task automatic test_count_wrap();
        int n;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            intf2.a        = 1'b1;
            intf2.b        = 1'b0;
            intf2.in_valid = 1'b1;
            #1;
            n = 0;
            while (!intf2.in_ready && n < 20) begin
                tick();
                n++;
            end
            tick();
            intf2.in_valid = 1'b0;
            n = 0;
            while (!intf2.out_valid && n < 10) begin
                tick();
                n++;
            end
            intf2.out_ready = 1'b1;
            tick();
            intf2.out_ready = 1'b0;
            vectors++;
            if (intf2.inf_count !== 2'(k)) begin
                miscompares++;
                $display("FAIL wrap handshake %0d: inf_count=%0d required %0d", k, intf2.inf_count, 2'(k));
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        intf.in_valid  = 1'b0;
        intf.a         = 1'b0;
        intf.b         = 1'b0;
        intf.cfg_we    = 1'b0;
        intf.cfg_addr  = 4'd0;
        intf.cfg_data  = 8'd0;
        intf.out_ready = 1'b0;
        intf2.in_valid  = 1'b0;
        intf2.a         = 1'b0;
        intf2.b         = 1'b0;
        intf2.cfg_we    = 1'b0;
        intf2.cfg_addr  = 4'd0;
        intf2.cfg_data  = 8'd0;
        intf2.out_ready = 1'b0;
        test_reset();
        test_nxor();
        test_xor();
        test_back_pressure();
        test_cfg_guard();
        test_extremes();
        test_reset_mid();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
